// File: rtl/async_fifo_wr_logic.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_logic
// Write-side control for the distributed-RAM async FIFO. Everything here runs
// in the write clock domain. The block owns the write pointer, the dpram write
// enable and the full / almost-full / fill-count flags. It resynchronises the
// read-domain Gray read pointer internally.
//
// Optional build macro: WR_OVERFLOW_FLAG_EN
//   defined   : o_overflow is a sticky flag. It sets one cycle after any write
//               request that arrives while the FIFO is full.
//   undefined : o_overflow is tied to 0 and no register is built.
//
// Ports
//   clk               write-domain clock
//   reset             synchronous, active-high
//   i_wr_en           write request
//   iv_rd_addr_gray   read pointer, Gray coded, asynchronous to clk
//   ov_wr_addr_bin    write pointer, binary
//   ov_wr_addr_gray   write pointer, Gray, registered (to read-domain sync)
//   ov_wr_addr_dpram  dpram write address (pointer without wrap MSB)
//   o_wr_en           dpram write enable (combinational)
//   o_fifo_full       full flag, registered
//   o_almost_full     almost-full flag, registered
//   ov_wr_count       fill level seen from the write side, registered
//   o_overflow        sticky overflow flag (see macro above)
// -----------------------------------------------------------------------------
module async_fifo_wr_logic #(
    parameter int ADDR_WIDTH         = 8,
    parameter int ALMOST_FULL_THRESH = 2**(ADDR_WIDTH-1) - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] iv_rd_addr_gray,
    output logic [ADDR_WIDTH-1:0] ov_wr_addr_bin,
    output logic [ADDR_WIDTH-1:0] ov_wr_addr_gray,
    output logic [ADDR_WIDTH-2:0] ov_wr_addr_dpram,
    output logic                  o_wr_en,
    output logic                  o_fifo_full,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH-1:0] ov_wr_count,
    output logic                  o_overflow
);

    localparam logic [ADDR_WIDTH-1:0] AF_THRESH = ADDR_WIDTH'(ALMOST_FULL_THRESH);

    logic [ADDR_WIDTH-1:0] sync1_q, sync1_d;
    logic [ADDR_WIDTH-1:0] sync2_q, sync2_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_gray_q, wr_gray_d;
    logic [ADDR_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;

    logic [ADDR_WIDTH-1:0] rd_bin_sync;
    logic [ADDR_WIDTH-1:0] wr_next;
    logic [ADDR_WIDTH-1:0] fill_next;
    logic                  valid_wr;

    always_comb begin
        // Gray to binary: bit i is the XOR of all Gray bits at or above i.
        rd_bin_sync = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rd_bin_sync[i] = ^(sync2_q >> i);
        end

        // Reset gates the enable so the dpram is never written while the
        // pointers are being cleared.
        valid_wr  = i_wr_en & ~full_q & ~reset;
        wr_next   = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, valid_wr};
        fill_next = wr_next - rd_bin_sync;

        sync1_d       = iv_rd_addr_gray;
        sync2_d       = sync1_q;
        wr_ptr_d      = wr_next;
        wr_gray_d     = wr_next ^ (wr_next >> 1);
        wr_count_d    = fill_next;
        // Wrap MSBs differ and the address bits match: DEPTH words outstanding.
        full_d        = (wr_next[ADDR_WIDTH-1] != rd_bin_sync[ADDR_WIDTH-1]) &&
                        (wr_next[ADDR_WIDTH-2:0] == rd_bin_sync[ADDR_WIDTH-2:0]);
        almost_full_d = (fill_next >= AF_THRESH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            wr_ptr_q      <= '0;
            wr_gray_q     <= '0;
            wr_count_q    <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_gray_q     <= wr_gray_d;
            wr_count_q    <= wr_count_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
        end
    end

`ifdef WR_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (i_wr_en & full_q);
    end

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign o_overflow = overflow_q;
`else
    assign o_overflow = 1'b0;
`endif

    assign ov_wr_addr_bin   = wr_ptr_q;
    assign ov_wr_addr_gray  = wr_gray_q;
    assign ov_wr_addr_dpram = wr_ptr_q[ADDR_WIDTH-2:0];
    assign o_wr_en          = valid_wr;
    assign o_fifo_full      = full_q;
    assign o_almost_full    = almost_full_q;
    assign ov_wr_count      = wr_count_q;

endmodule
